music_seq: RTL and testbench

- Note sequencer and tone generator for the music box.
- Consumes the 32nd-note beat square wave produced by the beat divider (50 MHz / 3 750 000 ≈ 13.33 Hz).
- Steps through an internal song ROM and holds each note for its programmed number of beats.
- Drives the buzzer pin with a square wave at the current note's pitch.

---
 rtl/music_pkg.sv | 56 +++++
 rtl/song_rom.sv | 28 ++
 rtl/music_seq.sv | 158 +++++++++++++++
 tb/tb_music_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the music box sequencer: pitch codes, the 50 MHz
// half-period table, sequencer state encoding and the song end marker.
package music_pkg;

    localparam logic [3:0] REST = 4'd0;
    localparam logic [3:0] C4   = 4'd1;
    localparam logic [3:0] CS4  = 4'd2;
    localparam logic [3:0] D4   = 4'd3;
    localparam logic [3:0] DS4  = 4'd4;
    localparam logic [3:0] E4   = 4'd5;
    localparam logic [3:0] F4   = 4'd6;
    localparam logic [3:0] FS4  = 4'd7;
    localparam logic [3:0] G4   = 4'd8;
    localparam logic [3:0] GS4  = 4'd9;
    localparam logic [3:0] A4   = 4'd10;
    localparam logic [3:0] AS4  = 4'd11;
    localparam logic [3:0] B4   = 4'd12;
    localparam logic [3:0] C5   = 4'd13;
    localparam logic [3:0] D5   = 4'd14;
    localparam logic [3:0] E5   = 4'd15;

    localparam logic [7:0] END_MARK = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_PLAY,
        S_GAP,
        S_PAUSED,
        S_DONE
    } state_t;

    // Clock cycles per half period, round(50e6 / (2 * f)).
    function automatic logic [16:0] pitch_half(input logic [3:0] p);
        case (p)
            C4:      return 17'd95556;
            CS4:     return 17'd90193;
            D4:      return 17'd85131;
            DS4:     return 17'd80353;
            E4:      return 17'd75843;
            F4:      return 17'd71586;
            FS4:     return 17'd67569;
            G4:      return 17'd63776;
            GS4:     return 17'd60197;
            A4:      return 17'd56818;
            AS4:     return 17'd53629;
            B4:      return 17'd50619;
            C5:      return 17'd47778;
            D5:      return 17'd42566;
            E5:      return 17'd37922;
            default: return 17'd0;
        endcase
    endfunction

endpackage

// File: rtl/song_rom.sv
// Song storage: one 8-bit word {pitch, beats} per address, registered read.
module song_rom
    import music_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        data
);

    logic [7:0] word;

    always_comb begin
        case (int'(addr))
            0:       word = {A4, 4'd2};
            1:       word = {REST, 4'd3};
            2:       word = {C5, 4'd1};
            3:       word = {E4, 4'd4};
            default: word = END_MARK;
        endcase
    end

    always_ff @(posedge clk) begin
        data <= word;
    end

endmodule

// File: rtl/music_seq.sv
// Note sequencer and tone generator: walks the song ROM one note at a time,
// counting beats from the beat divider and squaring the buzzer at the note pitch.
module music_seq
    import music_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int ADDR_W = 6,
    parameter bit LOOP   = 1'b0,
    parameter bit GAP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_in,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    output logic              buzzer,
    output logic              playing,
    output logic              song_done,
    output logic [ADDR_W-1:0] note_addr,
    output logic [3:0]        pitch
);

    // The half-period table only holds at 50 MHz; stay silent rather than off-key.
    localparam bit CLK_OK = (CLK_HZ == 50_000_000);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_reg, saved_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        pitch_reg, dur_cnt_reg;
    logic              playing_reg, done_reg;
    logic [7:0]        rom_data;
    logic              sync1_reg, sync2_reg, sync3_reg, tick_reg;
    logic [16:0]       tone_cnt_reg, half_per;
    logic              tone_reg, tone_en, pausable;

    song_rom #(.ADDR_W(ADDR_W)) u_rom (
        .clk  (clk),
        .addr (addr_reg),
        .data (rom_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            sync3_reg <= 1'b0;
            tick_reg  <= 1'b0;
        end else begin
            sync1_reg <= beat_in;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
            tick_reg  <= sync2_reg & ~sync3_reg;
        end
    end

    assign pausable = state_reg inside {S_LOAD, S_WAIT, S_PLAY, S_GAP};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            saved_reg   <= S_IDLE;
            addr_reg    <= '0;
            pitch_reg   <= REST;
            dur_cnt_reg <= 4'd0;
            playing_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (stop) begin
                state_reg   <= S_IDLE;
                addr_reg    <= '0;
                pitch_reg   <= REST;
                dur_cnt_reg <= 4'd0;
                playing_reg <= 1'b0;
            end else if (pause && pausable) begin
                saved_reg   <= state_reg;
                state_reg   <= S_PAUSED;
                playing_reg <= 1'b0;
            end else if (pause && state_reg == S_PAUSED) begin
                state_reg   <= saved_reg;
                playing_reg <= (saved_reg != S_WAIT);
            end else begin
                case (state_reg)
                    S_IDLE: if (start) begin
                        addr_reg    <= '0;
                        state_reg   <= S_LOAD;
                        playing_reg <= 1'b1;
                    end
                    S_LOAD: begin
                        state_reg   <= S_WAIT;
                        playing_reg <= 1'b0;
                    end
                    S_WAIT: if (rom_data == END_MARK) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        pitch_reg   <= rom_data[7:4];
                        dur_cnt_reg <= rom_data[3:0];
                        state_reg   <= S_PLAY;
                        playing_reg <= 1'b1;
                    end
                    // Reaching a count of 2 in PLAY already implies the note was 2+ beats long.
                    S_PLAY, S_GAP: if (tick_reg) begin
                        if (state_reg == S_PLAY && GAP_EN && dur_cnt_reg == 4'd2) begin
                            dur_cnt_reg <= 4'd1;
                            state_reg   <= S_GAP;
                        end else if (dur_cnt_reg <= 4'd1) begin
                            dur_cnt_reg <= 4'd0;
                            addr_reg    <= addr_reg + 1'b1;
                            if (addr_reg == LAST_ADDR) begin
                                state_reg   <= S_DONE;
                                done_reg    <= 1'b1;
                                playing_reg <= 1'b0;
                            end else begin
                                state_reg   <= S_LOAD;
                                playing_reg <= 1'b1;
                            end
                        end else begin
                            dur_cnt_reg <= dur_cnt_reg - 4'd1;
                        end
                    end
                    S_DONE: if (LOOP) begin
                        addr_reg    <= '0;
                        state_reg   <= S_LOAD;
                        playing_reg <= 1'b1;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign half_per = pitch_half(pitch_reg);
    assign tone_en  = CLK_OK && (state_reg == S_PLAY) && (pitch_reg != REST);

    // Any cycle outside an audible PLAY rewinds the phase, so every note starts low.
    always_ff @(posedge clk) begin
        if (rst || !tone_en) begin
            tone_cnt_reg <= 17'd0;
            tone_reg     <= 1'b0;
        end else if (tone_cnt_reg == half_per - 17'd1) begin
            tone_cnt_reg <= 17'd0;
            tone_reg     <= ~tone_reg;
        end else begin
            tone_cnt_reg <= tone_cnt_reg + 17'd1;
        end
    end

    assign buzzer    = tone_reg & tone_en;
    assign playing   = playing_reg;
    assign song_done = done_reg;
    assign note_addr = addr_reg;
    assign pitch     = pitch_reg;

endmodule

// File: tb/tb_music_seq.sv
// Randomized bench for music_seq: two configurations share one stimulus stream
// and are compared every cycle against a note-level reference model.
module tb_music_seq;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_SOUND = 2;
    localparam int M_END   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, beat_in = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0;

    logic       buz_a, ply_a, done_a, buz_b, ply_b, done_b;
    logic [5:0] addr_a;
    logic [1:0] addr_b;
    logic [3:0] pitch_a, pitch_b;

    music_seq #(.CLK_HZ(50_000_000), .ADDR_W(6), .LOOP(1'b0), .GAP_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .beat_in(beat_in), .start(start), .pause(pause), .stop(stop),
        .buzzer(buz_a), .playing(ply_a), .song_done(done_a), .note_addr(addr_a), .pitch(pitch_a)
    );

    music_seq #(.CLK_HZ(50_000_000), .ADDR_W(2), .LOOP(1'b1), .GAP_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .beat_in(beat_in), .start(start), .pause(pause), .stop(stop),
        .buzzer(buz_b), .playing(ply_b), .song_done(done_b), .note_addr(addr_b), .pitch(pitch_b)
    );

    int errors = 0;
    int checks = 0;
    bit bail = 1'b0;

    // Model configuration per instance and the song as written for the music box.
    int aw[2]     = '{6, 2};
    bit loop_p[2] = '{1'b0, 1'b1};
    bit gap_p[2]  = '{1'b1, 1'b0};
    logic [7:0] rom_img[5] = '{8'hA2, 8'h03, 8'hD1, 8'h54, 8'h00};
    int half_tab[16];

    int m_mode[2], m_fetch[2], m_addr[2], m_pitch[2], m_dur[2], m_left[2], m_snd[2];
    bit m_paused[2], m_aud[2];
    logic [3:0] bhist = 4'b0;

    task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
            if (errors > 40) bail = 1'b1;
        end
    endtask

    // Equal temperament around A4 = 440 Hz, half period in 50 MHz cycles.
    function automatic int half_of(input int p);
        int semis;
        real f;
        if (p <= 12) semis = p - 10;
        else if (p == 13) semis = 3;
        else if (p == 14) semis = 5;
        else semis = 7;
        f = 440.0 * (2.0 ** (real'(semis) / 12.0));
        return $rtoi(50_000_000.0 / (2.0 * f) + 0.5);
    endfunction

    function automatic logic [7:0] rom_word(input int a);
        return (a < 5) ? rom_img[a] : 8'h00;
    endfunction

    task automatic model_edge(input int i, input logic r, input logic s, input logic p,
                              input logic st, input logic tick);
        int last;
        logic [7:0] w;
        bit aud, in_gap;
        last = (1 << aw[i]) - 1;
        if (r) begin
            m_mode[i] = M_IDLE; m_paused[i] = 1'b0; m_addr[i] = 0; m_pitch[i] = 0;
            m_dur[i] = 0; m_left[i] = 0; m_fetch[i] = 0;
        end else if (st) begin
            m_mode[i] = M_IDLE; m_paused[i] = 1'b0; m_addr[i] = 0; m_pitch[i] = 0; m_left[i] = 0;
        end else if (p && m_paused[i]) begin
            m_paused[i] = 1'b0;
        end else if (p && (m_mode[i] == M_FETCH || m_mode[i] == M_SOUND)) begin
            m_paused[i] = 1'b1;
        end else if (!m_paused[i]) begin
            case (m_mode[i])
                M_IDLE: if (s) begin
                    m_addr[i] = 0; m_mode[i] = M_FETCH; m_fetch[i] = 2;
                end
                M_FETCH: if (m_fetch[i] == 2) begin
                    m_fetch[i] = 1;
                end else begin
                    w = rom_word(m_addr[i]);
                    if (w == 8'h00) m_mode[i] = M_END;
                    else begin
                        m_pitch[i] = int'(w[7:4]); m_dur[i] = int'(w[3:0]);
                        m_left[i] = m_dur[i]; m_mode[i] = M_SOUND;
                    end
                end
                M_SOUND: if (tick) begin
                    m_left[i]--;
                    if (m_left[i] <= 0) begin
                        if (m_addr[i] == last) begin
                            m_addr[i] = 0; m_mode[i] = M_END;
                        end else begin
                            m_addr[i]++; m_mode[i] = M_FETCH; m_fetch[i] = 2;
                        end
                    end
                end
                default: if (loop_p[i]) begin
                    m_addr[i] = 0; m_mode[i] = M_FETCH; m_fetch[i] = 2;
                end else begin
                    m_mode[i] = M_IDLE;
                end
            endcase
        end
        in_gap = gap_p[i] && m_dur[i] >= 2 && m_left[i] == 1;
        aud = !m_paused[i] && m_mode[i] == M_SOUND && m_pitch[i] != 0 && !in_gap;
        m_snd[i] = (aud && m_aud[i]) ? m_snd[i] + 1 : 0;
        m_aud[i] = aud;
    endtask

    function automatic logic [12:0] exp_vec(input int i);
        logic ply, done, buz;
        ply  = !m_paused[i] && ((m_mode[i] == M_FETCH && m_fetch[i] == 2) || m_mode[i] == M_SOUND);
        done = (m_mode[i] == M_END);
        buz  = m_aud[i] && (((m_snd[i] / half_tab[m_pitch[i]]) % 2) == 1);
        return {buz, ply, done, 4'(m_pitch[i]), 6'(m_addr[i])};
    endfunction

    task automatic step(input logic r, input logic s, input logic p, input logic st, input logic b);
        logic tick;
        @(negedge clk);
        rst = r; start = s; pause = p; stop = st; beat_in = b;
        @(posedge clk);
        tick = bhist[2] & ~bhist[3];
        for (int i = 0; i < 2; i++) model_edge(i, r, s, p, st, tick);
        bhist = r ? 4'b0 : {bhist[2:0], b};
        #1;
        check_eq("dut_a", {buz_a, ply_a, done_a, pitch_a, addr_a}, exp_vec(0));
        check_eq("dut_b", {buz_b, ply_b, done_b, pitch_b, 4'b0, addr_b}, exp_vec(1));
    endtask

    initial begin
        int rv;
        logic bl;
        for (int p = 1; p < 16; p++) half_tab[p] = half_of(p);
        half_tab[0] = 1;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_paused[i] = 1'b0; m_aud[i] = 1'b0; m_snd[i] = 0;
            m_addr[i] = 0; m_pitch[i] = 0; m_dur[i] = 0; m_left[i] = 0; m_fetch[i] = 0;
        end

        for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Long A4 note: beats spaced far enough apart to watch full half periods.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 58000 && !bail; n++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 4 && !bail; n++)     step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 2000 && !bail; n++)  step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 4 && !bail; n++)     step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 400 && !bail; n++)   step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Fast random beats with start/pause/stop/reset mixed in.
        bl = 1'b0;
        for (int n = 0; n < 20000 && !bail; n++) begin
            rv = int'($urandom_range(0, 999));
            if ($urandom_range(0, 3) == 0) bl = ~bl;
            step(rv == 0, rv >= 1 && rv <= 40, rv >= 41 && rv <= 56, rv >= 57 && rv <= 59, bl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
